// File: rtl/gpio_periph_if.sv
// Data-port bus bundle (mem_d_* protocol) between the core/decoder and gpio_periph.
// Signal names match the peripheral's port naming; the master drives the *_i side.
interface gpio_periph_if;
    logic        sel_i;
    logic [31:0] addr_i;
    logic [31:0] data_wr_i;
    logic        rd_i;
    logic [3:0]  wr_i;
    logic [10:0] req_tag_i;
    logic        accept_o;
    logic        ack_o;
    logic        error_o;
    logic [31:0] data_rd_o;
    logic [10:0] resp_tag_o;

    modport slave (
        input  sel_i, addr_i, data_wr_i, rd_i, wr_i, req_tag_i,
        output accept_o, ack_o, error_o, data_rd_o, resp_tag_o
    );

    modport master (
        output sel_i, addr_i, data_wr_i, rd_i, wr_i, req_tag_i,
        input  accept_o, ack_o, error_o, data_rd_o, resp_tag_o
    );
endinterface

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO: per-pin direction, atomic set/clear, synchronised inputs,
// edge-triggered interrupts with write-one-to-clear status, single-cycle bus response.
module gpio_periph #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    gpio_periph_if.slave     bus,
    input  logic [WIDTH-1:0] gpio_in_i,
    output logic [WIDTH-1:0] gpio_out_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] ARM_CYC = CNT_W'(SYNC_STAGES + 1);

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [CNT_W-1:0] arm_q, arm_d;
    logic             irq_q;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [10:0]      tag_q, tag_d;

    logic             req, wr_any, we, re;
    logic [3:0]       off;
    logic [31:0]      lane_full;
    logic [WIDTH-1:0] lane_m, dmask, in_w, rise, fall, evt;
    logic             unused_ok;

    assign wr_any    = |bus.wr_i;
    assign req       = bus.sel_i & (bus.rd_i | wr_any);
    assign off       = bus.addr_i[5:2];
    // Offsets 8..15 are the error window: no state change, no read data.
    assign we        = req & wr_any & ~off[3];
    assign re        = req & ~wr_any & ~off[3];
    assign lane_full = {{8{bus.wr_i[3]}}, {8{bus.wr_i[2]}}, {8{bus.wr_i[1]}}, {8{bus.wr_i[0]}}};
    assign lane_m    = lane_full[WIDTH-1:0];
    assign dmask     = bus.data_wr_i[WIDTH-1:0] & lane_m;
    assign unused_ok = ^{bus.addr_i[31:6], bus.addr_i[1:0], bus.data_wr_i};

    assign in_w = sync_q[SYNC_STAGES-1];
    assign rise = in_w & ~prev_q;
    assign fall = ~in_w & prev_q;
    // Suppress events until the synchroniser holds post-reset pin values.
    assign evt  = (arm_q == ARM_CYC) ? ((edge_q & rise) | (~edge_q & fall)) : '0;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ie_d     = ie_q;
        edge_d   = edge_q;
        status_d = status_q;
        arm_d    = (arm_q == ARM_CYC) ? arm_q : arm_q + 1'b1;
        if (we) begin
            case (off[2:0])
                3'd0:    out_d    = (out_q & ~lane_m) | dmask;
                3'd1:    dir_d    = (dir_q & ~lane_m) | dmask;
                3'd3:    ie_d     = (ie_q & ~lane_m) | dmask;
                3'd4:    edge_d   = (edge_q & ~lane_m) | dmask;
                3'd5:    status_d = status_q & ~dmask;
                3'd6:    out_d    = out_q | dmask;
                3'd7:    out_d    = out_q & ~dmask;
                default: ;
            endcase
        end
        // A new event outranks a same-cycle clear.
        status_d = status_d | evt;
    end

    always_comb begin
        ack_d   = req;
        err_d   = req & off[3];
        tag_d   = req ? bus.req_tag_i : tag_q;
        rdata_d = '0;
        if (re) begin
            case (off[2:0])
                3'd0:    rdata_d = zext(out_q);
                3'd1:    rdata_d = zext(dir_q);
                3'd2:    rdata_d = zext(in_w);
                3'd3:    rdata_d = zext(ie_q);
                3'd4:    rdata_d = zext(edge_q);
                3'd5:    rdata_d = zext(status_q);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q    <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            edge_q   <= '0;
            status_q <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
            arm_q    <= '0;
            irq_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            tag_q    <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            ie_q     <= ie_d;
            edge_q   <= edge_d;
            status_q <= status_d;
            prev_q   <= in_w;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
            arm_q    <= arm_d;
            irq_q    <= |(status_q & ie_q);
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.accept_o   = ~rst_i;
    assign bus.ack_o      = ack_q;
    assign bus.error_o    = err_q;
    assign bus.data_rd_o  = rdata_q;
    assign bus.resp_tag_o = tag_q;
    assign gpio_out_o     = out_q;
    assign gpio_oe_o      = dir_q;
    assign irq_o          = irq_q;

endmodule
